// File: rtl/fadd_iq_if.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_iq_if
//  Purpose  : Bundles the signals between the fadd issue queue and the blocks
//             around it: the FPU dispatcher (in_*), the pipelined fadd core
//             (fa_*), and the result consumer (out_*).
//  Modports : slave  - the issue queue itself
//             master - the environment (dispatcher, fadd core and consumer)
//  Ports    : in_valid/in_ready/in_x1/in_x2/in_tag  operand handshake
//             fa_x1/fa_x2 -> fadd, fa_y/fa_ovf <- fadd
//             out_valid/out_ready/out_y/out_ovf/out_tag  result handshake
//  Revision : 1.0  initial release
// ============================================================================
interface fadd_iq_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fa_x1;
    logic [31:0]      fa_x2;
    logic [31:0]      fa_y;
    logic             fa_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_x1, in_x2, in_tag, fa_y, fa_ovf, out_ready,
        output in_ready, fa_x1, fa_x2, out_valid, out_y, out_ovf, out_tag
    );

    modport master (
        output in_valid, in_x1, in_x2, in_tag, fa_y, fa_ovf, out_ready,
        input  in_ready, fa_x1, fa_x2, out_valid, out_y, out_ovf, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/fadd_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_issue_queue
//  Purpose  : Issue/retire wrapper for a non-stallable pipelined fadd core.
//             Accepts operand pairs over valid/ready, registers them into the
//             fadd, tracks tags alongside the fadd pipeline and captures the
//             results into a result FIFO. A credit count (FIFO entries plus
//             ops in flight) stops issue before the FIFO could overflow.
//  Ports    : clk, rstn (async, active-low)
//             bus (fadd_iq_if.slave): in_* handshake, fa_* fadd link,
//             out_* result handshake
//             ovf_sticky (out), ovf_clr (in) - only with FADD_OVF_STICKY_EN
//  Config   : FADD_OVF_STICKY_EN - adds a sticky overflow flag set by any
//             popped result with ovf=1, cleared by ovf_clr (set wins).
//  Revision : 1.0  initial release
// ============================================================================
module fadd_issue_queue #(
    parameter int NSTAGE     = 2,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rstn,
    fadd_iq_if.slave  bus
`ifdef FADD_OVF_STICKY_EN
    ,
    output logic      ovf_sticky,
    input  logic      ovf_clr
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + NSTAGE + 2);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    // Valid/tag shift registers that mirror the fadd pipeline.
    logic [NSTAGE:0]  v_q, v_d;
    logic [TAG_W-1:0] tag_q [NSTAGE+1];
    logic [31:0]      fa_x1_q, fa_x2_q;

    // Result FIFO storage and bookkeeping.
    logic [31:0]      mem_y_q   [FIFO_DEPTH];
    logic             mem_ovf_q [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept, push, pop, out_valid, in_ready;

    // count covers every op that still owns a FIFO slot (queued or in
    // flight), so a push can never land in a full FIFO without a pop.
    assign in_ready  = rstn && (count_q < CNT_W'(FIFO_DEPTH));
    assign accept    = bus.in_valid && in_ready;
    assign push      = v_q[NSTAGE];
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.fa_x1     = fa_x1_q;
    assign bus.fa_x2     = fa_x2_q;
    assign bus.out_valid = out_valid;
    assign bus.out_y     = mem_y_q[rd_q];
    assign bus.out_ovf   = mem_ovf_q[rd_q];
    assign bus.out_tag   = mem_tag_q[rd_q];

    always_comb begin
        v_d  = {v_q[NSTAGE-1:0], accept};
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) begin
            wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q     <= '0;
            fa_x1_q <= '0;
            fa_x2_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            count_q <= '0;
            for (int k = 0; k <= NSTAGE; k++) begin
                tag_q[k] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_y_q[i]   <= '0;
                mem_ovf_q[i] <= 1'b0;
                mem_tag_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            count_q <= count_d;
            // Operands hold when nothing is accepted; fadd output for those
            // cycles is never captured because v[0] is 0.
            if (accept) begin
                fa_x1_q  <= bus.in_x1;
                fa_x2_q  <= bus.in_x2;
                tag_q[0] <= bus.in_tag;
            end
            for (int k = 1; k <= NSTAGE; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            if (push) begin
                mem_y_q[wr_q]   <= bus.fa_y;
                mem_ovf_q[wr_q] <= bus.fa_ovf;
                mem_tag_q[wr_q] <= tag_q[NSTAGE];
            end
        end
    end

`ifdef FADD_OVF_STICKY_EN
    logic ovf_sticky_q;
    assign ovf_sticky = ovf_sticky_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_sticky_q <= 1'b0;
        end else if (pop && bus.out_ovf) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn) begin
            assert (!(push && !pop && occ_q == OCC_W'(FIFO_DEPTH)))
                else $error("fadd_issue_queue: result push into full FIFO");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fadd_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fadd_issue_queue
//  Purpose  : Bench for fadd_issue_queue with a behavioural fadd core
//             (NSTAGE=2). Issued ops are pushed into an expected-result queue;
//             a monitor compares outputs, in_ready and out_valid timing
//             against that queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fadd_issue_queue;
    localparam int NSTAGE     = 2;
    localparam int TAG_W      = 5;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fadd_iq_if #(.TAG_W(TAG_W)) bus ();

`ifdef FADD_OVF_STICKY_EN
    logic ovf_sticky;
    logic ovf_clr = 1'b0;
`endif

    fadd_issue_queue #(.NSTAGE(NSTAGE), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus.slave)
`ifdef FADD_OVF_STICKY_EN
        ,
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural single-precision add ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {ovf, y}; round to nearest even, overflow -> signed infinity.
    function automatic logic [32:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
        real         r;
        logic [63:0] d;
        int          e;
        logic [23:0] m;
        logic [28:0] rem;
        r = f2r(a) + f2r(b);
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {1'b0, d[63], 31'd0};
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {1'b0, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 24'd1;
        if (m[23]) begin
            m = 24'd0;
            e = e + 1;
        end
        if (e >= 255) return {1'b1, d[63], 8'hff, 23'd0};
        if (e <= 0) return {1'b0, d[63], 31'd0};
        return {1'b0, d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [7:0] e;
        e = ($urandom_range(0, 31) == 0) ? 8'd254 : 8'($urandom_range(110, 140));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // fadd core model: samples fa_x each edge, result NSTAGE edges later.
    logic [32:0] fpipe [NSTAGE];
    initial for (int k = 0; k < NSTAGE; k++) fpipe[k] = '0;
    always @(posedge clk) begin
        fpipe[0] <= fadd_ref(bus.fa_x1, bus.fa_x2);
        for (int k = 1; k < NSTAGE; k++) fpipe[k] <= fpipe[k-1];
    end
    assign bus.fa_y   = fpipe[NSTAGE-1][31:0];
    assign bus.fa_ovf = fpipe[NSTAGE-1][32];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        int               acc;   // edge number at which the op was accepted
        logic [31:0]      y;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    // Issue side: an op seen valid&&ready here is accepted at the next edge.
    always @(negedge clk) begin
        if (rstn && bus.in_valid && bus.in_ready) begin
            logic [32:0] r;
            r = fadd_ref(bus.in_x1, bus.in_x2);
            sb.push_back('{acc: cyc + 1, y: r[31:0], ovf: r[32], tag: bus.in_tag});
        end
    end

`ifdef FADD_OVF_STICKY_EN
    bit sticky_m = 1'b0;
`endif

    // Monitor: an op owns a slot from its accept edge until popped, and its
    // result is visible from NSTAGE+1 edges after acceptance.
    always @(negedge clk) begin
        int outst;
        bit hv;
        if (!rstn) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
`ifdef FADD_OVF_STICKY_EN
            sticky_m = 1'b0;
`endif
        end else begin
            outst = 0;
            foreach (sb[i]) if (sb[i].acc <= cyc) outst++;
            hv = (sb.size() > 0) && (sb[0].acc + NSTAGE + 1 <= cyc);
            chk("in_ready", bus.in_ready, (outst < FIFO_DEPTH));
            chk("out_valid", bus.out_valid, hv);
            if (hv && bus.out_valid) begin
                chk("out_y", bus.out_y, sb[0].y);
                chk("out_ovf", bus.out_ovf, sb[0].ovf);
                chk("out_tag", bus.out_tag, sb[0].tag);
            end
`ifdef FADD_OVF_STICKY_EN
            chk("ovf_sticky", ovf_sticky, sticky_m);
            if (hv && bus.out_valid && bus.out_ready && sb[0].ovf) sticky_m = 1'b1;
            else if (ovf_clr) sticky_m = 1'b0;
`endif
            if (hv && bus.out_valid && bus.out_ready) void'(sb.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x1 = a;
        bus.in_x2 = b;
        bus.in_tag = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("wait_out_valid", bus.out_valid, 1);
    endtask

    task automatic rand_op();
        bus.in_x1 = rnd_f();
        bus.in_x2 = rnd_f();
        bus.in_tag = TAG_W'($urandom);
    endtask

    initial begin
        int a_edge;
        int n;
        int pops;
        logic [5:0] pat;
        bit acc;
        bus.in_valid  = 1'b0;
        bus.in_x1     = '0;
        bus.in_x2     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_out_y", bus.out_y, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_fa_x1", bus.fa_x1, 0);
        chk("rst_fa_x2", bus.fa_x2, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.in_ready, 1);

        // 1.0 + 2.0: latency and value
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h3f80_0000, 32'h4000_0000, 5'd3);
        a_edge = cyc;
        wait_valid();
        chk("t1_latency", cyc - a_edge, NSTAGE + 1);
        chk("t1_y", bus.out_y, 32'h4040_0000);
        chk("t1_ovf", bus.out_ovf, 0);
        chk("t1_tag", bus.out_tag, 3);

        // Overflow to infinity
        @(posedge clk);
        #1;
        send(32'h7f7f_ffff, 32'h7f7f_ffff, 5'd1);
        wait_valid();
        chk("t2_y", bus.out_y, 32'h7f80_0000);
        chk("t2_ovf", bus.out_ovf, 1);
        chk("t2_tag", bus.out_tag, 1);
`ifdef FADD_OVF_STICKY_EN
        @(negedge clk);
        chk("t2_sticky_set", ovf_sticky, 1);
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("t2_sticky_clr", ovf_sticky, 0);
`endif

        // Back-pressure fill: exactly FIFO_DEPTH accepts
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        repeat (12) begin
            bus.in_x1 = rnd_f();
            bus.in_x2 = rnd_f();
            bus.in_tag = TAG_W'(n);
            @(negedge clk);
            if (bus.in_ready) n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("t3_accepts", n, FIFO_DEPTH);
        @(negedge clk);
        chk("t3_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        pat = '0;
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = bus.out_valid;
            if (bus.out_valid) pops++;
        end
        chk("t3_drain_pattern", pat, 6'b00_1111);
        chk("t3_pops", pops, 4);

        // 200 back-to-back random ops, consumer always ready
        @(posedge clk);
        #1;
        n = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2000 && n < 200; i++) begin
            rand_op();
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) n++;
        end
        bus.in_valid = 1'b0;
        chk("t4_ops", n, 200);
        repeat (10) @(posedge clk);
        #1;

        // 10k random ops with random back-pressure
        n = 0;
        for (int i = 0; i < 60000 && n < 10000; i++) begin
            rand_op();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
`ifdef FADD_OVF_STICKY_EN
            ovf_clr = ($urandom_range(0, 7) == 0);
`endif
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) n++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
`ifdef FADD_OVF_STICKY_EN
        ovf_clr = 1'b0;
`endif
        chk("t5_ops", n, 10000);
        repeat (10) @(posedge clk);
        #1;

        // Reset with results queued and in flight
        bus.out_ready = 1'b0;
        send(32'h3f80_0000, 32'h3f80_0000, 5'd10);
        send(32'h4000_0000, 32'h4000_0000, 5'd11);
        repeat (5) @(posedge clk);
        #1;
        send(32'h4040_0000, 32'h3f80_0000, 5'd12);
        send(32'h4080_0000, 32'h3f80_0000, 5'd13);
        #1 rstn = 1'b0;
        sb.delete();
        #1;
        chk("t6_async_out_valid", bus.out_valid, 0);
        chk("t6_async_in_ready", bus.in_ready, 0);
        chk("t6_async_out_y", bus.out_y, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        send(32'h4040_0000, 32'h3f80_0000, 5'd7);
        wait_valid();
        chk("t6_y", bus.out_y, 32'h4080_0000);
        chk("t6_tag", bus.out_tag, 7);
        repeat (4) @(posedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
